png_byte_serializer: RTL

- Upstream feeder for the PNG decoder: accepts wide NIC packets (552 bits = 69 bytes) on a valid/ready handshake and streams their bytes one per cycle to the decoder's ivalid/iready/ibyte input.
- Issues the decoder's istart pulse before the first byte of each image.
- Two packet slots (ping-pong): one slot refills while the other drains, so bytes stream with no bubbles across packets.
- Replaces the load/shift-driven buffer with a self-timed, flow-controlled stage.

---
 rtl/png_pkg.sv | 22 ++
 rtl/png_pkt_slot2.sv | 99 +++++++++
 rtl/png_byte_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/png_pkg.sv
// Shared definitions for the PNG byte serializer.
//   PktBytesDef - default bytes per NIC packet
//   CntWDef     - default width of byte counters (2**CntWDef > PktBytesDef)
//   png_state_e - serializer FSM states
//   byte_lsb()  - bit offset of byte idx in an MSB-first packet of nbytes bytes
package png_pkg;

  localparam int unsigned PktBytesDef = 69;
  localparam int unsigned CntWDef     = 7;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StStream
  } png_state_e;

  // Byte 0 sits in the most significant byte lane.
  function automatic int unsigned byte_lsb(input int unsigned idx, input int unsigned nbytes);
    return 8 * (nbytes - 1 - idx);
  endfunction

endpackage

// File: rtl/png_pkt_slot2.sv
// Two-entry ping-pong packet store feeding the serializer.
// Ports:
//   clk, rstn     - clock, asynchronous active-low reset
//   wr_en         - capture wr_data/wr_nbytes/wr_last into the write slot
//   wr_data       - packet payload, byte 0 in the MSBs
//   wr_nbytes     - valid byte count; 0 or > PKT_BYTES is clamped to PKT_BYTES
//   wr_last       - packet closes the current image
//   free          - release the head slot (applied before a same-cycle write)
//   head_occ      - head slot holds a packet
//   head_data     - head slot payload
//   head_nbytes   - head slot byte count (already clamped)
//   head_last     - head slot last flag
//   other_occ     - the non-head slot holds a packet
//   any_occ       - at least one slot is occupied
//   ready         - registered "not full"
module png_pkt_slot2 import png_pkg::*; #(
  parameter int unsigned PKT_BYTES = PktBytesDef,
  parameter int unsigned CNT_W     = CntWDef
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  logic [8*PKT_BYTES-1:0] wr_data,
  input  logic [CNT_W-1:0]       wr_nbytes,
  input  logic                   wr_last,
  input  logic                   free,
  output logic                   head_occ,
  output logic [8*PKT_BYTES-1:0] head_data,
  output logic [CNT_W-1:0]       head_nbytes,
  output logic                   head_last,
  output logic                   other_occ,
  output logic                   any_occ,
  output logic                   ready
);

  localparam logic [CNT_W-1:0] MaxBytes = CNT_W'(PKT_BYTES);

  logic [8*PKT_BYTES-1:0] data_q [2];
  logic [CNT_W-1:0]       nbytes_q [2];
  logic [1:0]             last_q;
  logic [1:0]             occ_q, occ_d;
  logic                   wr_ptr_q, rd_ptr_q;
  logic                   ready_q;
  logic [CNT_W-1:0]       nbytes_clamped;

  assign nbytes_clamped = (wr_nbytes == '0 || wr_nbytes > MaxBytes) ? MaxBytes : wr_nbytes;

  // Free before write so a slot drained this cycle can be refilled at once.
  always_comb begin
    occ_d = occ_q;
    if (free) begin
      occ_d[rd_ptr_q] = 1'b0;
    end
    if (wr_en) begin
      occ_d[wr_ptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      occ_q   <= occ_d;
      ready_q <= ~&occ_d;
      if (free) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (wr_en) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q[0]   <= '0;
      data_q[1]   <= '0;
      nbytes_q[0] <= '0;
      nbytes_q[1] <= '0;
      last_q      <= '0;
    end else if (wr_en) begin
      data_q[wr_ptr_q]   <= wr_data;
      nbytes_q[wr_ptr_q] <= nbytes_clamped;
      last_q[wr_ptr_q]   <= wr_last;
    end
  end

  assign head_occ    = occ_q[rd_ptr_q];
  assign head_data   = data_q[rd_ptr_q];
  assign head_nbytes = nbytes_q[rd_ptr_q];
  assign head_last   = last_q[rd_ptr_q];
  assign other_occ   = occ_q[~rd_ptr_q];
  assign any_occ     = |occ_q;
  assign ready       = ready_q;

endmodule

// File: rtl/png_byte_serializer.sv
// Streams wide NIC packets byte-by-byte into the PNG decoder, issuing an
// istart pulse before the first byte of each image.
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   pkt_valid    - input packet present
//   pkt_ready    - a slot is free (registered, no path from oready)
//   pkt_data     - packet, byte 0 in the MSBs
//   pkt_nbytes   - valid bytes from byte 0 (0 or > PKT_BYTES means PKT_BYTES)
//   pkt_last     - packet ends the current image
//   ostart       - one-cycle pulse to decoder istart
//   ovalid       - obyte valid
//   oready       - decoder ready
//   obyte        - output byte
//   busy         - a slot is occupied or the FSM is not idle
module png_byte_serializer import png_pkg::*; #(
  parameter int unsigned PKT_BYTES = PktBytesDef,
  parameter int unsigned CNT_W     = CntWDef
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic [8*PKT_BYTES-1:0] pkt_data,
  input  logic [CNT_W-1:0]       pkt_nbytes,
  input  logic                   pkt_last,
  output logic                   ostart,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [7:0]             obyte,
  output logic                   busy
);

  png_state_e             state_q, state_d;
  logic [CNT_W-1:0]       rd_idx_q, rd_idx_d;
  logic                   need_start_q, need_start_d;
  logic                   wr_en;
  logic                   slot_free;
  logic                   head_occ, head_last, other_occ, any_occ;
  logic [8*PKT_BYTES-1:0] head_data;
  logic [CNT_W-1:0]       head_nbytes;

  assign wr_en = pkt_valid && pkt_ready;

  png_pkt_slot2 #(
    .PKT_BYTES (PKT_BYTES),
    .CNT_W     (CNT_W)
  ) u_slots (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en       (wr_en),
    .wr_data     (pkt_data),
    .wr_nbytes   (pkt_nbytes),
    .wr_last     (pkt_last),
    .free        (slot_free),
    .head_occ    (head_occ),
    .head_data   (head_data),
    .head_nbytes (head_nbytes),
    .head_last   (head_last),
    .other_occ   (other_occ),
    .any_occ     (any_occ),
    .ready       (pkt_ready)
  );

  always_comb begin
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    need_start_d = need_start_q;
    slot_free    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Both slots are empty in idle, so an incoming write lands in the
        // head slot; looking at it now saves a cycle of latency.
        if (head_occ || wr_en) begin
          rd_idx_d = '0;
          state_d  = need_start_q ? StStart : StStream;
        end
      end
      StStart: begin
        need_start_d = 1'b0;
        rd_idx_d     = '0;
        state_d      = StStream;
      end
      StStream: begin
        if (oready) begin
          if (rd_idx_q == head_nbytes - CNT_W'(1)) begin
            slot_free    = 1'b1;
            need_start_d = need_start_q | head_last;
            rd_idx_d     = '0;
            if (other_occ) begin
              state_d = need_start_d ? StStart : StStream;
            end else begin
              state_d = StIdle;
            end
          end else begin
            rd_idx_d = rd_idx_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      rd_idx_q     <= '0;
      need_start_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      need_start_q <= need_start_d;
    end
  end

  assign ostart = (state_q == StStart);
  assign ovalid = (state_q == StStream);
  assign obyte  = ovalid ? head_data[byte_lsb(32'(rd_idx_q), PKT_BYTES) +: 8] : 8'h00;
  assign busy   = any_occ || (state_q != StIdle);

endmodule
